// File: rtl/ecg_report_arbiter.sv
// Arbitrates QRS-detector beat reports and periodic threshold status reports
// onto one byte-wide valid/ready TX channel, framing each report as bytes.
module ecg_report_arbiter #(
  parameter int DATA_WIDTH    = 11,
  parameter int CTR_WIDTH     = 24,
  parameter int FIFO_DEPTH    = 4,
  parameter int STATUS_PERIOD = 360
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic                  i_alg_active,
  input  logic [DATA_WIDTH-1:0] i_rr_period,
  input  logic                  i_rr_period_updated,
  input  logic [CTR_WIDTH-1:0]  i_r_peak_location,
  input  logic [DATA_WIDTH-1:0] i_qrs_threshold,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int              AW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW            = $clog2(STATUS_PERIOD + 1);
  localparam logic [CW-1:0]   STATUS_LAST   = CW'(STATUS_PERIOD - 1);
  localparam logic [AW:0]     FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]      BEAT_SYNC     = 8'hA5;
  localparam logic [7:0]      STATUS_SYNC   = 8'h5A;

  typedef enum logic { S_IDLE, S_SEND } state_t;
  typedef enum logic { G_BEAT, G_STATUS } grant_t;

  typedef struct packed {
    logic [23:0] loc;
    logic [15:0] rr;
  } beat_t;

  // Beat FIFO
  beat_t          r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;
  beat_t          w_push_data;
  beat_t          w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_drop;

  // Status timer
  logic [CW-1:0]         r_status_ctr;
  logic                  r_status_pending;
  logic [DATA_WIDTH-1:0] r_th_snap;
  logic [15:0]           w_th;

  // Framer FSM
  state_t      r_state;
  grant_t      r_last_grant;
  logic [7:0]  r_frame [6];
  logic [2:0]  r_idx;
  logic [2:0]  r_last_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [2:0]  w_next_idx;
  logic        w_grant_beat;
  logic        w_grant_status;

  assign w_push_data = beat_t'{loc: 24'(i_r_peak_location), rr: 16'(i_rr_period)};
  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_full      = (r_count == FIFO_FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = w_grant_beat;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push      = i_rr_period_updated && (!w_full || w_pop);
  assign w_drop      = i_rr_period_updated && w_full && !w_pop;
  assign w_th        = 16'(r_th_snap);
  assign w_next_idx  = r_idx + 3'd1;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant_beat   = 1'b0;
    w_grant_status = 1'b0;
    if (r_state == S_IDLE) begin
      if (!w_empty && r_status_pending) begin
        if (r_last_grant == G_STATUS) w_grant_beat   = 1'b1;
        else                          w_grant_status = 1'b1;
      end else if (!w_empty) begin
        w_grant_beat = 1'b1;
      end else if (r_status_pending) begin
        w_grant_status = 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; r_count alone says which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_status_ctr     <= '0;
      r_status_pending <= 1'b0;
      r_th_snap        <= '0;
    end else begin
      if (w_grant_status) r_status_pending <= 1'b0;
      // A wrap on the grant edge re-arms the request with the fresh snapshot.
      if (!i_alg_active) begin
        r_status_ctr <= '0;
      end else if (i_ce) begin
        if (r_status_ctr == STATUS_LAST) begin
          r_status_ctr     <= '0;
          r_status_pending <= 1'b1;
          r_th_snap        <= i_qrs_threshold;
        end else begin
          r_status_ctr <= r_status_ctr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_last_grant <= G_STATUS;
      r_idx        <= '0;
      r_last_idx   <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      for (int i = 0; i < 6; i++) r_frame[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_beat) begin
            r_frame[0]   <= BEAT_SYNC;
            r_frame[1]   <= w_head.loc[23:16];
            r_frame[2]   <= w_head.loc[15:8];
            r_frame[3]   <= w_head.loc[7:0];
            r_frame[4]   <= w_head.rr[15:8];
            r_frame[5]   <= w_head.rr[7:0];
            r_last_idx   <= 3'd5;
            r_last_grant <= G_BEAT;
            r_idx        <= '0;
            r_tx_data    <= BEAT_SYNC;
            r_tx_valid   <= 1'b1;
            r_state      <= S_SEND;
          end else if (w_grant_status) begin
            r_frame[0]   <= STATUS_SYNC;
            r_frame[1]   <= w_th[15:8];
            r_frame[2]   <= w_th[7:0];
            r_last_idx   <= 3'd2;
            r_last_grant <= G_STATUS;
            r_idx        <= '0;
            r_tx_data    <= STATUS_SYNC;
            r_tx_valid   <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_tx_ready) begin
            if (r_idx == r_last_idx) begin
              // Dropping to IDLE guarantees one valid-low cycle between frames.
              r_tx_valid <= 1'b0;
              r_idx      <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= r_frame[w_next_idx];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != S_IDLE) | !w_empty | r_status_pending;

endmodule

// File: tb/tb_ecg_report_arbiter.sv
// Directed self-checking bench for ecg_report_arbiter: framing, latency,
// arbitration alternation, stalls, overflow, status coalescing and reset abort.
module tb_ecg_report_arbiter;

  logic        clk;
  logic        nrst;
  logic        ce;
  logic        alg_active;
  logic [10:0] rr_period;
  logic        rr_updated;
  logic [23:0] r_peak_loc;
  logic [10:0] qrs_thr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q  [$];
  logic [7:0] exp_q [$];

  ecg_report_arbiter dut (
    .i_clk               (clk),
    .i_nrst              (nrst),
    .i_ce                (ce),
    .i_alg_active        (alg_active),
    .i_rr_period         (rr_period),
    .i_rr_period_updated (rr_updated),
    .i_r_peak_location   (r_peak_loc),
    .i_qrs_threshold     (qrs_thr),
    .o_tx_data           (tx_data),
    .o_tx_valid          (tx_valid),
    .i_tx_ready          (tx_ready),
    .o_overflow          (overflow),
    .o_busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte monitor: a byte is accepted at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (nrst && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nrst       = 1'b0;
    ce         = 1'b0;
    alg_active = 1'b0;
    rr_updated = 1'b0;
    tx_ready   = 1'b0;
    step(2);
    nrst = 1'b1;
    step(1);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_beat(input logic [23:0] loc, input logic [10:0] rr);
    r_peak_loc = loc;
    rr_period  = rr;
    rr_updated = 1'b1;
    step(1);
    rr_updated = 1'b0;
  endtask

  task automatic add_beat(input logic [23:0] loc, input logic [10:0] rr);
    logic [15:0] rr16;
    rr16 = 16'(rr);
    exp_q.push_back(8'hA5);
    exp_q.push_back(loc[23:16]);
    exp_q.push_back(loc[15:8]);
    exp_q.push_back(loc[7:0]);
    exp_q.push_back(rr16[15:8]);
    exp_q.push_back(rr16[7:0]);
  endtask

  task automatic add_status(input logic [10:0] th);
    logic [15:0] th16;
    th16 = 16'(th);
    exp_q.push_back(8'h5A);
    exp_q.push_back(th16[15:8]);
    exp_q.push_back(th16[7:0]);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!tx_valid && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 64'(tx_valid), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [7:0] t1_bytes [6];
    logic [23:0] loc_v;
    logic [10:0] rr_v;

    nrst       = 1'b0;
    ce         = 1'b0;
    alg_active = 1'b0;
    rr_updated = 1'b0;
    tx_ready   = 1'b0;
    rr_period  = '0;
    r_peak_loc = '0;
    qrs_thr    = '0;
    step(2);

    // Reset state
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    nrst = 1'b1;
    step(1);

    // Single beat: latency t+2 and consecutive bytes
    t1_bytes = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h01, 8'h2C};
    tx_ready = 1'b1;
    pulse_beat(24'h012345, 11'd300);
    check("lat_t1_valid", 64'(tx_valid), 64'd0);
    step(1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("beat1_valid[%0d]", k), 64'(tx_valid), 64'd1);
      check($sformatf("beat1_byte[%0d]", k), 64'(tx_data), 64'(t1_bytes[k]));
      step(1);
    end
    check("beat1_gap_valid", 64'(tx_valid), 64'd0);
    check("beat1_busy", 64'(busy), 64'd0);
    rx_q.delete();

    // Status frame with a 5-cycle stall mid-frame
    do_reset();
    tx_ready   = 1'b1;
    qrs_thr    = 11'h155;
    alg_active = 1'b1;
    ce         = 1'b1;
    step(360);
    ce         = 1'b0;
    alg_active = 1'b0;
    wait_valid("status_valid_seen", 10);
    check("status_first", 64'(tx_data), 64'h5A);
    step(1);
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check($sformatf("stall_data[%0d]", k), 64'(tx_data), 64'h01);
      check($sformatf("stall_valid[%0d]", k), 64'(tx_valid), 64'd1);
    end
    tx_ready = 1'b1;
    wait_idle("status_idle", 20);
    add_status(11'h155);
    compare_rx("status_frame");

    // Both pending from reset: beat first; both pending again: status first
    do_reset();
    tx_ready   = 1'b1;
    qrs_thr    = 11'h2AA;
    alg_active = 1'b1;
    ce         = 1'b1;
    step(359);
    r_peak_loc = 24'h00ABCD;
    rr_period  = 11'h123;
    rr_updated = 1'b1;
    step(1);
    rr_updated = 1'b0;
    ce         = 1'b0;
    alg_active = 1'b0;
    step(3);
    pulse_beat(24'hFFFFFF, 11'h7FF);
    wait_idle("alt_idle", 100);
    add_beat(24'h00ABCD, 11'h123);
    add_status(11'h2AA);
    add_beat(24'hFFFFFF, 11'h7FF);
    compare_rx("alternation");

    // Two status periods during a stalled backlog: one frame, latest snapshot
    do_reset();
    pulse_beat(24'h111111, 11'd50);
    pulse_beat(24'h222222, 11'd60);
    alg_active = 1'b1;
    ce         = 1'b1;
    qrs_thr    = 11'h0AA;
    step(360);
    qrs_thr    = 11'h3CC;
    step(360);
    ce         = 1'b0;
    alg_active = 1'b0;
    check("coalesce_stalled_data", 64'(tx_data), 64'hA5);
    tx_ready = 1'b1;
    wait_idle("coalesce_idle", 100);
    add_beat(24'h111111, 11'd50);
    add_status(11'h3CC);
    add_beat(24'h222222, 11'd60);
    compare_rx("coalesce");

    // Full FIFO with a pop on the same edge accepts the push
    do_reset();
    for (int i = 0; i < 5; i++) pulse_beat(24'(32'h000A0B0C + i * 32'h00010101), 11'(200 + i));
    check("full_no_overflow", 64'(overflow), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    tx_ready = 1'b1;
    step(6);
    check("full_idle_gap", 64'(tx_valid), 64'd0);
    pulse_beat(24'h0F0F0F, 11'd77);
    check("full_pop_push_no_ovf", 64'(overflow), 64'd0);
    wait_idle("full_idle", 100);
    for (int i = 0; i < 5; i++) add_beat(24'(32'h000A0B0C + i * 32'h00010101), 11'(200 + i));
    add_beat(24'h0F0F0F, 11'd77);
    compare_rx("full_pop_push");

    // Overflow: 1 in frame + 4 buffered, 6th dropped, sticky
    do_reset();
    for (int i = 0; i < 6; i++) pulse_beat(24'(32'h00102030 + i * 32'h00010101), 11'(100 + i));
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_stalled_data", 64'(tx_data), 64'hA5);
    step(10);
    check("ovf_sticky_stalled", 64'(overflow), 64'd1);
    tx_ready = 1'b1;
    wait_idle("ovf_idle", 200);
    for (int i = 0; i < 5; i++) add_beat(24'(32'h00102030 + i * 32'h00010101), 11'(100 + i));
    compare_rx("ovf_drain");
    check("ovf_sticky_after", 64'(overflow), 64'd1);

    // Reset during byte 3 of a beat frame with one more beat queued
    loc_v = 24'h6789AB;
    rr_v  = 11'd400;
    pulse_beat(loc_v, rr_v);
    pulse_beat(24'h0C0D0E, 11'd9);
    wait_valid("abort_valid_seen", 10);
    check("abort_byte0", 64'(tx_data), 64'hA5);
    step(2);
    check("abort_byte2", 64'(tx_data), 64'(loc_v[15:8]));
    #1;
    nrst = 1'b0;
    #1;
    check("abort_valid", 64'(tx_valid), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    step(2);
    nrst = 1'b1;
    rx_q.delete();
    step(20);
    check("abort_no_residual", 64'(rx_q.size()), 64'd0);
    check("abort_valid_after", 64'(tx_valid), 64'd0);
    check("abort_busy_after", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
